// File: rtl/decode_pkg.sv
// Shared encodings, control bundle and history-entry types for the decode stage.
package decode_pkg;
  localparam int WORD_W_P = 16;
  localparam int RA_W_P   = 3;
  localparam int ALU_W_P  = 4;

  localparam logic [1:0] CLS_LD  = 2'b00;
  localparam logic [1:0] CLS_ST  = 2'b01;
  localparam logic [1:0] CLS_IMM = 2'b10;
  localparam logic [1:0] CLS_ALU = 2'b11;

  localparam logic [3:0] FN_CMP = 4'b0101;
  localparam logic [3:0] FN_MOV = 4'b0110;
  localparam logic [3:0] FN_IN  = 4'b1100;
  localparam logic [3:0] FN_OUT = 4'b1101;

  localparam logic [2:0] SUB_LI   = 3'b000;
  localparam logic [2:0] SUB_ADDI = 3'b001;
  localparam logic [2:0] SUB_B    = 3'b100;
  localparam logic [2:0] SUB_BCC  = 3'b111;

  localparam logic [ALU_W_P-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALU_W_P-1:0] ALU_SUB = 4'b0001;
  localparam logic [ALU_W_P-1:0] ALU_IDT = 4'b1100;
  localparam logic [ALU_W_P-1:0] ALU_NON = 4'b1111;

  typedef struct packed {
    logic [ALU_W_P-1:0] alu_sel;
    logic               wr_en;
    logic [RA_W_P-1:0]  wr_addr;
    logic               mem_re;
    logic               mem_we;
    logic               imm_sext;
    logic               pc_load;
  } ctrl_t;

  typedef struct packed {
    logic              valid;
    logic              writes;
    logic [RA_W_P-1:0] dest;
    logic              is_load;
  } hist_t;

  typedef enum logic {ST_RUN, ST_BUBBLE} state_t;

  localparam ctrl_t CTRL_RST = '{ALU_NON, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0};
endpackage

// File: rtl/decode_fields.sv
// Pure combinational instruction decode: control bundle plus operand-use and destination info.
module decode_fields
  import decode_pkg::*;
(
  input  logic [WORD_W_P-1:0] cmd,
  output ctrl_t               ctrl,
  output logic                reads_a,
  output logic                reads_b,
  output logic [RA_W_P-1:0]   dest,
  output logic                writes,
  output logic                is_load
);
  logic [1:0]        cls;
  logic [RA_W_P-1:0] fa, fb;
  logic [2:0]        sub;
  logic [3:0]        func;
  logic              unused_lo;

  assign cls       = cmd[15:14];
  assign fa        = cmd[13:11];
  assign fb        = cmd[10:8];
  assign sub       = cmd[13:11];
  assign func      = cmd[7:4];
  assign unused_lo = ^cmd[3:0];

  always_comb begin
    ctrl          = CTRL_RST;
    reads_a       = 1'b0;
    reads_b       = 1'b0;
    is_load       = (cls == CLS_LD);
    dest          = is_load ? fa : fb;
    ctrl.imm_sext = (cls != CLS_ALU);
    case (cls)
      CLS_LD: begin
        ctrl.alu_sel = ALU_ADD;
        ctrl.wr_en   = 1'b1;
        ctrl.mem_re  = 1'b1;
        reads_b      = 1'b1;
      end
      CLS_ST: begin
        ctrl.alu_sel = ALU_ADD;
        ctrl.mem_we  = 1'b1;
        reads_a      = 1'b1;
        reads_b      = 1'b1;
      end
      CLS_IMM: begin
        case (sub)
          SUB_LI: begin
            ctrl.alu_sel = ALU_IDT;
            ctrl.wr_en   = 1'b1;
          end
          SUB_ADDI: begin
            ctrl.alu_sel = ALU_ADD;
            ctrl.wr_en   = 1'b1;
            reads_b      = 1'b1;
          end
          SUB_B, SUB_BCC: begin
            ctrl.alu_sel = ALU_ADD;
            ctrl.pc_load = 1'b1;
          end
          default: ctrl.alu_sel = ALU_NON;
        endcase
      end
      default: begin
        // CMP reuses the subtractor, MOV passes B through; other funcs select the ALU directly
        ctrl.alu_sel = (func == FN_CMP) ? ALU_SUB : (func == FN_MOV) ? ALU_IDT : func;
        ctrl.wr_en   = (func <= FN_IN) && (func != FN_CMP);
        reads_a      = (func != FN_IN);
        reads_b      = (func != FN_IN);
      end
    endcase
    ctrl.wr_addr = dest;
    writes       = ctrl.wr_en;
  end
endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready slot, issue history, one-hot forwarding and load-use bubble.
module decode_stage
  import decode_pkg::*;
#(
  parameter int WORD_W    = 16,
  parameter int RA_W      = 3,
  parameter int FWD_DEPTH = 2,
  parameter int ALU_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_W-1:0]    in_cmd,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [WORD_W-1:0]    out_cmd,
  output logic [ALU_W-1:0]     alu_sel,
  output logic                 wr_en,
  output logic [RA_W-1:0]      wr_addr,
  output logic                 mem_re,
  output logic                 mem_we,
  output logic                 imm_sext,
  output logic                 pc_load,
  output logic [FWD_DEPTH-1:0] fwd_a,
  output logic [FWD_DEPTH-1:0] fwd_b,
  output logic                 hazard_stall
);
  ctrl_t                 dec_ctrl, ctrl_q;
  logic                  rd_a, rd_b, dec_wr, dec_ld;
  logic [RA_W-1:0]       dec_dest, src_a, src_b;
  hist_t [FWD_DEPTH-1:0] hist;
  hist_t                 new_entry;
  logic [FWD_DEPTH-1:0]  hit_a, hit_b, fwd_a_d, fwd_b_d;
  logic                  slot_free, hazard, accept, bubble;
  state_t                state, state_d;

  decode_fields u_dec (
    .cmd(in_cmd), .ctrl(dec_ctrl), .reads_a(rd_a), .reads_b(rd_b),
    .dest(dec_dest), .writes(dec_wr), .is_load(dec_ld)
  );

  assign src_a = in_cmd[13:11];
  assign src_b = in_cmd[10:8];

  for (genvar k = 0; k < FWD_DEPTH; k++) begin : g_cmp
    assign hit_a[k] = rd_a & hist[k].valid & hist[k].writes & (hist[k].dest == src_a);
    assign hit_b[k] = rd_b & hist[k].valid & hist[k].writes & (hist[k].dest == src_b);
  end

  // isolate lowest set bit: the most recent matching producer wins
  assign fwd_a_d = hit_a & (~hit_a + FWD_DEPTH'(1));
  assign fwd_b_d = hit_b & (~hit_b + FWD_DEPTH'(1));

  assign hazard    = in_valid & hist[0].valid & hist[0].is_load &
                     ((rd_a & (src_a == hist[0].dest)) | (rd_b & (src_b == hist[0].dest)));
  assign slot_free = !out_valid | out_ready;
  assign in_ready  = slot_free & !flush & !hazard & (state == ST_RUN);
  assign accept    = in_valid & in_ready;
  assign bubble    = (state == ST_RUN) & hazard & slot_free & !flush;
  assign new_entry = accept ? '{1'b1, dec_wr, dec_dest, dec_ld} : '0;

  always_comb begin
    state_d = state;
    if (flush) state_d = ST_RUN;
    else begin
      case (state)
        ST_RUN:    if (bubble) state_d = ST_BUBBLE;
        ST_BUBBLE: state_d = ST_RUN;
        default:   state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      hist <= '0;
    end else if (accept || bubble) begin
      hist[0] <= new_entry;
      for (int k = 1; k < FWD_DEPTH; k++) hist[k] <= hist[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_cmd      <= '0;
      ctrl_q       <= CTRL_RST;
      fwd_a        <= '0;
      fwd_b        <= '0;
      hazard_stall <= 1'b0;
    end else if (flush) begin
      out_valid    <= 1'b0;
      hazard_stall <= 1'b0;
    end else if (slot_free) begin
      out_valid    <= accept;
      hazard_stall <= bubble;
      if (accept) begin
        out_cmd <= in_cmd;
        ctrl_q  <= dec_ctrl;
        fwd_a   <= fwd_a_d;
        fwd_b   <= fwd_b_d;
      end
    end
  end

  assign alu_sel  = ctrl_q.alu_sel;
  assign wr_en    = ctrl_q.wr_en;
  assign wr_addr  = ctrl_q.wr_addr;
  assign mem_re   = ctrl_q.mem_re;
  assign mem_we   = ctrl_q.mem_we;
  assign imm_sext = ctrl_q.imm_sext;
  assign pc_load  = ctrl_q.pc_load;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vector table plus forwarding, hazard, backpressure and flush sequences.
module tb_decode_stage;
  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, wr_en, mem_re, mem_we, imm_sext, pc_load, hazard_stall;
  logic [15:0] in_cmd = '0, out_cmd;
  logic [3:0]  alu_sel;
  logic [2:0]  wr_addr;
  logic [1:0]  fwd_a, fwd_b;
  int          checks = 0, errors = 0;

  decode_stage #(.WORD_W(16), .RA_W(3), .FWD_DEPTH(2), .ALU_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .out_ready(out_ready), .out_valid(out_valid), .out_cmd(out_cmd),
    .alu_sel(alu_sel), .wr_en(wr_en), .wr_addr(wr_addr), .mem_re(mem_re), .mem_we(mem_we),
    .imm_sext(imm_sext), .pc_load(pc_load), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cmd;
    logic [3:0]  alu;
    logic        wr;
    logic [2:0]  addr;
    logic        re, we, sext, pc;
  } vec_t;

  vec_t vecs[13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flush_pulse();
    in_valid = 1'b0;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{16'hCA00, 4'h0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{16'hCA50, 4'h1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{16'hCC60, 4'hC, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{16'h1A00, 4'h0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{16'h5A00, 4'h0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{16'h8500, 4'hC, 1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{16'h8E00, 4'h0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{16'hA000, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{16'hB800, 4'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{16'h9000, 4'hF, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{16'hCAD0, 4'hD, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{16'hCAC0, 4'hC, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{16'hCA30, 4'h3, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0};

    // reset state
    repeat (3) step();
    check("reset_outs",
          {out_valid, alu_sel, wr_en, wr_addr, mem_re, mem_we, imm_sext, pc_load, fwd_a, fwd_b, hazard_stall, out_cmd},
          {1'b0, 4'hF, 1'b0, 3'd0, 4'b0, 2'b00, 2'b00, 1'b0, 16'h0000});
    rst = 1'b0;
    #1;
    check("reset_in_ready", in_ready, 1'b1);

    // decode table, each vector issued from an empty history
    for (int i = 0; i < 13; i++) begin
      flush_pulse();
      in_valid = 1'b1;
      in_cmd   = vecs[i].cmd;
      #1;
      check($sformatf("vec%0d_in_ready", i), in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      check($sformatf("vec%0d_bundle", i),
            {out_valid, alu_sel, wr_en, (wr_en ? wr_addr : 3'd0), mem_re, mem_we, imm_sext, pc_load,
             fwd_a, fwd_b, hazard_stall, out_cmd},
            {1'b1, vecs[i].alu, vecs[i].wr, (vecs[i].wr ? vecs[i].addr : 3'd0), vecs[i].re, vecs[i].we,
             vecs[i].sext, vecs[i].pc, 2'b00, 2'b00, 1'b0, vecs[i].cmd});
    end

    // back-to-back forwarding from the most recent instruction
    flush_pulse();
    in_valid = 1'b1; in_cmd = 16'hCA00;
    step();
    in_cmd = 16'hDA00;
    step();
    check("fwd_b2b", {out_valid, fwd_a, fwd_b, hazard_stall, out_cmd}, {1'b1, 2'b00, 2'b01, 1'b0, 16'hDA00});
    in_cmd = 16'hCAC0;
    step();
    in_valid = 1'b0;
    check("fwd_in_reads_none", {out_valid, fwd_a, fwd_b}, {1'b1, 2'b00, 2'b00});

    // load-use hazard: bubble, idle, then issue forwarding from hist[1]
    flush_pulse();
    in_valid = 1'b1; in_cmd = 16'h1A00;
    step();
    in_cmd = 16'hDC00;
    #1;
    check("hz_block", in_ready, 1'b0);
    step();
    check("hz_stall", {hazard_stall, out_valid, in_ready}, 3'b100);
    step();
    check("hz_idle", {hazard_stall, out_valid, in_ready}, 3'b001);
    step();
    in_valid = 1'b0;
    check("hz_issue", {out_valid, fwd_a, fwd_b, hazard_stall, out_cmd}, {1'b1, 2'b10, 2'b00, 1'b0, 16'hDC00});

    // backpressure holds the slot and the history
    flush_pulse();
    in_valid = 1'b1; in_cmd = 16'hCA00;
    step();
    in_cmd = 16'hDA00; out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_hold%0d", i), {in_ready, out_valid, out_cmd, wr_en, wr_addr, alu_sel},
            {1'b0, 1'b1, 16'hCA00, 1'b1, 3'd2, 4'h0});
      step();
    end
    check("bp_hold3", {in_ready, out_valid, out_cmd}, {1'b0, 1'b1, 16'hCA00});
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    check("bp_release", {out_valid, out_cmd, fwd_a, fwd_b}, {1'b1, 16'hDA00, 2'b00, 2'b01});

    // flush during the bubble wins over the pending instruction and clears history
    flush_pulse();
    in_valid = 1'b1; in_cmd = 16'h1A00;
    step();
    in_cmd = 16'hDC00;
    step();
    flush = 1'b1;
    #1;
    check("fl_block", in_ready, 1'b0);
    step();
    flush = 1'b0;
    #1;
    check("fl_after", {out_valid, hazard_stall, in_ready}, 3'b001);
    in_cmd = 16'hDA00;
    step();
    in_valid = 1'b0;
    check("fl_next", {out_valid, out_cmd, fwd_a, fwd_b}, {1'b1, 16'hDA00, 2'b00, 2'b00});

    // reset while backpressured discards slot and history
    flush_pulse();
    in_valid = 1'b1; in_cmd = 16'hCA00;
    step();
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b1;
    #1;
    check("rst_mid_bp", {out_valid, alu_sel, wr_en, out_cmd}, {1'b0, 4'hF, 1'b0, 16'h0000});
    in_valid = 1'b1; in_cmd = 16'hDA00;
    step();
    in_valid = 1'b0;
    check("rst_hist_clear", {out_valid, fwd_a, fwd_b}, {1'b1, 2'b00, 2'b00});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
